// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants and types for the APB interrupt controller.
package apb_irq_ctrl_pkg;

  localparam int unsigned CTRL_A     = 'h000;
  localparam int unsigned EDGE_CFG_A = 'h004;
  localparam int unsigned ENABLE_A   = 'h008;
  localparam int unsigned PENDING_A  = 'h00C;
  localparam int unsigned CLAIM_A    = 'h010;
  localparam int unsigned INSVC_A    = 'h014;

  localparam int NUM_SRC_DEF = 8;

  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

  localparam int ID_W = id_width(NUM_SRC_DEF);

  typedef enum logic [1:0] {IDLE, PENDING, IN_SERVICE} src_state_e;

endpackage

// File: rtl/apb_irq_ctrl_if.sv
// APB3 slave bus bundle used between the core fabric and the interrupt controller.
interface apb_irq_ctrl_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_irq_ctrl_src_cell.sv
// One interrupt source: synchroniser, rising-edge detect, pending latch and in-service bit.
module irq_src_cell
  import apb_irq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src,
  input  logic       edge_mode,
  input  logic       w1c,
  input  logic       claim,
  input  logic       complete,
  output logic       pending,
  output logic       in_service,
  output src_state_e state
);

  logic sync1, sync2, dly, pending_q, rise;

  assign rise = sync2 & ~dly;

  // A fresh edge beats a same-cycle W1C or claim so no request is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      dly        <= 1'b0;
      pending_q  <= 1'b0;
      in_service <= 1'b0;
    end else begin
      sync1      <= src;
      sync2      <= sync1;
      dly        <= sync2;
      pending_q  <= edge_mode & (rise | (pending_q & ~(w1c | claim)));
      in_service <= (in_service | claim) & ~complete;
    end
  end

  assign pending = edge_mode ? pending_q : sync2;

  always_comb begin
    state = IDLE;
    if (in_service)   state = IN_SERVICE;
    else if (pending) state = PENDING;
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: register decode, fixed-priority claim and registered irq_o.
module apb_irq_ctrl
  import apb_irq_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = NUM_SRC_DEF
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  apb_irq_ctrl_if.slave      apb,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o
);

  localparam int IDW = id_width(NUM_SRC);

  logic               ctrl_en;
  logic [NUM_SRC-1:0] edge_cfg, enable, pending, in_service, eligible, grant;
  logic [NUM_SRC-1:0] claim_vec, w1c_vec, complete_vec;
  logic [IDW-1:0]     claim_id;
  src_state_e         state [NUM_SRC];
  logic access, wr, rd, is_ctrl, is_edge, is_enable, is_pending, is_claim, is_insvc;
  logic mapped, bad_id;

  assign access     = apb.PSEL & apb.PENABLE;
  assign wr         = access & apb.PWRITE;
  assign rd         = access & ~apb.PWRITE;
  assign is_ctrl    = apb.PADDR == APB_ADDR_WIDTH'(CTRL_A);
  assign is_edge    = apb.PADDR == APB_ADDR_WIDTH'(EDGE_CFG_A);
  assign is_enable  = apb.PADDR == APB_ADDR_WIDTH'(ENABLE_A);
  assign is_pending = apb.PADDR == APB_ADDR_WIDTH'(PENDING_A);
  assign is_claim   = apb.PADDR == APB_ADDR_WIDTH'(CLAIM_A);
  assign is_insvc   = apb.PADDR == APB_ADDR_WIDTH'(INSVC_A);
  assign mapped     = is_ctrl | is_edge | is_enable | is_pending | is_claim | is_insvc;
  assign bad_id     = (apb.PWDATA == 32'd0) | (apb.PWDATA > 32'(NUM_SRC));

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (~mapped | (apb.PWRITE & is_claim & bad_id));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cell u_cell (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .src        (irq_src_i[g]),
      .edge_mode  (edge_cfg[g]),
      .w1c        (w1c_vec[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g]),
      .state      (state[g])
    );
    assign eligible[g] = (state[g] == PENDING) & enable[g];
  end

  // Lowest index wins: scanning downward leaves the smallest eligible index last.
  always_comb begin
    grant    = '0;
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        claim_id = IDW'(i + 1);
      end
    end
  end

  always_comb begin
    claim_vec    = grant & {NUM_SRC{rd & is_claim}};
    w1c_vec      = apb.PWDATA[NUM_SRC-1:0] & {NUM_SRC{wr & is_pending}};
    complete_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      complete_vec[i] = wr & is_claim & (apb.PWDATA == 32'(i + 1));
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL) begin
      if (is_ctrl)    apb.PRDATA = {31'd0, ctrl_en};
      if (is_edge)    apb.PRDATA = 32'(edge_cfg);
      if (is_enable)  apb.PRDATA = 32'(enable);
      if (is_pending) apb.PRDATA = 32'(pending);
      if (is_claim)   apb.PRDATA = 32'(claim_id);
      if (is_insvc)   apb.PRDATA = 32'(in_service);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en  <= 1'b0;
      edge_cfg <= '0;
      enable   <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr & is_ctrl)   ctrl_en  <= apb.PWDATA[0];
      if (wr & is_edge)   edge_cfg <= apb.PWDATA[NUM_SRC-1:0];
      if (wr & is_enable) enable   <= apb.PWDATA[NUM_SRC-1:0];
      irq_o <= ctrl_en & |eligible;
    end
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed and randomized bench for apb_irq_ctrl against a cycle-level behavioural model.
module tb_apb_irq_ctrl;
  import apb_irq_ctrl_pkg::*;

  localparam int N = 8;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b1;
  logic [N-1:0] irq_src_i = '0;
  logic         irq_o;

  apb_irq_ctrl_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .NUM_SRC(N)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .apb       (bus),
    .irq_src_i (irq_src_i),
    .irq_o     (irq_o)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  bit jitter = 1'b0;

  // Model state: register contents, latched edge requests, in-service set, and input history.
  bit           m_ctrl, m_irq;
  bit [N-1:0]   m_edge, m_en, m_lat, m_insvc;
  bit [N-1:0]   m_hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_ctrl = 0; m_irq = 0; m_edge = '0; m_en = '0; m_lat = '0; m_insvc = '0;
    m_hist = '{'0, '0, '0};
  endtask

  // The synchronised view of a source is its input two clock edges ago.
  function automatic bit [N-1:0] modelPending();
    bit [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_edge[i] ? m_lat[i] : m_hist[1][i];
    return p;
  endfunction

  function automatic int modelClaimId();
    bit [N-1:0] p = modelPending();
    for (int i = 0; i < N; i++)
      if (p[i] && m_en[i] && !m_insvc[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] a);
    int unsigned ai = a;
    case (ai)
      CTRL_A:     return {31'd0, m_ctrl};
      EDGE_CFG_A: return 32'(m_edge);
      ENABLE_A:   return 32'(m_en);
      PENDING_A:  return 32'(modelPending());
      CLAIM_A:    return 32'(modelClaimId());
      INSVC_A:    return 32'(m_insvc);
      default:    return 32'd0;
    endcase
  endfunction

  function automatic bit modelErr(input bit wr, input logic [11:0] a, input logic [31:0] d);
    int unsigned ai = a;
    bit unmapped = !(ai inside {CTRL_A, EDGE_CFG_A, ENABLE_A, PENDING_A, CLAIM_A, INSVC_A});
    return unmapped || (wr && ai == CLAIM_A && (d == 0 || d > N));
  endfunction

  task automatic modelStep(input bit acc, input bit wr, input logic [11:0] a,
                           input logic [31:0] d, input logic [N-1:0] src);
    int unsigned ai = a;
    int id = modelClaimId();
    bit [N-1:0] p = modelPending();
    m_irq = m_ctrl && ((p & m_en & ~m_insvc) != 0);
    for (int i = 0; i < N; i++) begin
      bit rise = m_hist[1][i] && !m_hist[2][i];
      bit clm  = acc && !wr && ai == CLAIM_A && id == i + 1;
      bit w1c  = acc && wr && ai == PENDING_A && d[i];
      bit cmp  = acc && wr && ai == CLAIM_A && d == i + 1;
      if (!m_edge[i])      m_lat[i] = 0;
      else if (rise)       m_lat[i] = 1;
      else if (clm || w1c) m_lat[i] = 0;
      if (cmp)      m_insvc[i] = 0;
      else if (clm) m_insvc[i] = 1;
    end
    if (acc && wr) begin
      if (ai == CTRL_A)     m_ctrl = d[0];
      if (ai == EDGE_CFG_A) m_edge = d[N-1:0];
      if (ai == ENABLE_A)   m_en   = d[N-1:0];
    end
    m_hist.push_front(src);
    void'(m_hist.pop_back());
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance model on the rising edge.
  task automatic applyStimulus(input bit sel, input bit en, input bit wr, input logic [11:0] a,
                               input logic [31:0] d, output logic [31:0] rdata, output logic err);
    if (jitter) irq_src_i = irq_src_i ^ N'($urandom & $urandom & $urandom);
    bus.PSEL = sel; bus.PENABLE = en; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    #1;
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    checkOutput("irq_o", irq_o, m_irq);
    if (sel) checkOutput("prdata", rdata, modelRead(a));
    checkOutput("pslverr", err, (sel && en) ? modelErr(wr, a, d) : 1'b0);
    @(posedge HCLK);
    modelStep(sel && en, wr, a, d, irq_src_i);
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd; logic er;
    repeat (n) applyStimulus(0, 0, 0, '0, '0, rd, er);
  endtask

  task automatic apbAccess(input bit wr, input logic [11:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output logic err);
    applyStimulus(1, 0, wr, a, d, rdata, err);
    applyStimulus(1, 1, wr, a, d, rdata, err);
  endtask

  task automatic readCheck(input string tag, input int unsigned a, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    apbAccess(0, 12'(a), '0, rd, er);
    checkOutput(tag, rd, exp);
  endtask

  task automatic writeReg(input int unsigned a, input logic [31:0] d);
    logic [31:0] rd; logic er;
    apbAccess(1, 12'(a), d, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned regs[6] = '{CTRL_A, EDGE_CFG_A, ENABLE_A, PENDING_A, CLAIM_A, INSVC_A};

    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    modelReset();
    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_pready", bus.PREADY, 1);
    HRESETn = 1'b1;
    foreach (regs[k]) readCheck("rst_reg", regs[k], 0);

    $display("[TB] timer path latency and claim");
    writeReg(EDGE_CFG_A, 1); writeReg(ENABLE_A, 1); writeReg(CTRL_A, 1);
    irq_src_i[0] = 1'b1;
    idle(3);
    checkOutput("lat3", irq_o, 0);
    idle(1);
    checkOutput("lat4", irq_o, 1);
    readCheck("claim_timer", CLAIM_A, 1);
    idle(1);
    checkOutput("irq_drop", irq_o, 0);
    writeReg(CLAIM_A, 1);
    readCheck("insvc_done", INSVC_A, 0);
    irq_src_i[0] = 1'b0;

    $display("[TB] priority");
    writeReg(EDGE_CFG_A, 'hFF); writeReg(ENABLE_A, 'hFF);
    irq_src_i = 8'h0A; idle(1); irq_src_i = '0; idle(4);
    readCheck("prio1", CLAIM_A, 2);
    readCheck("prio2", CLAIM_A, 4);
    readCheck("prio3", CLAIM_A, 0);
    readCheck("prio_pend", PENDING_A, 0);
    writeReg(CLAIM_A, 2); writeReg(CLAIM_A, 4);
    readCheck("prio_insvc", INSVC_A, 0);

    $display("[TB] level source");
    writeReg(EDGE_CFG_A, 0);
    irq_src_i[5] = 1'b1; idle(3);
    readCheck("lvl_claim", CLAIM_A, 6);
    writeReg(CLAIM_A, 6);
    checkOutput("lvl_irq_lo", irq_o, 0);
    idle(1);
    checkOutput("lvl_irq_hi", irq_o, 1);
    irq_src_i[5] = 1'b0; idle(2);
    readCheck("lvl_drop", PENDING_A, 0);

    $display("[TB] error responses");
    apbAccess(0, 12'h020, '0, rd, er);
    checkOutput("bad_addr_err", er, 1);
    checkOutput("bad_addr_data", rd, 0);
    writeReg(EDGE_CFG_A, 'hFF);
    irq_src_i[0] = 1'b1; idle(4); irq_src_i[0] = 1'b0;
    readCheck("claim0", CLAIM_A, 1);
    apbAccess(1, 12'(CLAIM_A), 0, rd, er);
    checkOutput("cmp_id0_err", er, 1);
    apbAccess(1, 12'(CLAIM_A), N + 1, rd, er);
    checkOutput("cmp_big_err", er, 1);
    apbAccess(1, 12'(CLAIM_A), 3, rd, er);
    checkOutput("cmp_idle_err", er, 0);
    readCheck("insvc_kept", INSVC_A, 1);

    $display("[TB] races");
    irq_src_i[2] = 1'b1; idle(1); irq_src_i[2] = 1'b0; idle(4);
    irq_src_i[2] = 1'b1; idle(1);
    writeReg(PENDING_A, 'h4);
    readCheck("race_pend", PENDING_A, 'h4);
    irq_src_i[2] = 1'b0;
    HRESETn = 1'b0;
    #1 checkOutput("rst_mid_irq", irq_o, 0);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PADDR = 12'(INSVC_A);
    #1 checkOutput("rst_mid_insvc", bus.PRDATA, 0);
    modelReset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle(2);
    readCheck("post_rst_insvc", INSVC_A, 0);

    $display("[TB] randomized traffic");
    writeReg(EDGE_CFG_A, $urandom); writeReg(ENABLE_A, 'hFF); writeReg(CTRL_A, 1);
    jitter = 1'b1;
    repeat (400) begin
      case ($urandom_range(0, 7))
        0:       idle(1);
        1, 2:    apbAccess(0, 12'(CLAIM_A), '0, rd, er);
        3:       apbAccess(1, 12'(CLAIM_A), $urandom_range(0, N + 1), rd, er);
        4:       apbAccess(1, 12'(PENDING_A), $urandom, rd, er);
        5:       apbAccess(0, 12'(4 * $urandom_range(0, 8)), '0, rd, er);
        6:       apbAccess(1, 12'(4 * $urandom_range(0, 2)), $urandom | 1, rd, er);
        default: apbAccess(1, 12'(4 * $urandom_range(3, 8)), $urandom, rd, er);
      endcase
    end
    jitter = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_irq_ctrl.md
Name: apb_irq_ctrl

Overview:
APB-slave interrupt controller sitting directly downstream of apb_timer. It consumes irq_o from the timer and up to NUM_SRC-1 other peripherals. Each source is synchronised, edge- or level-qualified, latched as pending, masked, and arbitrated by fixed priority (lowest index wins). The result is presented to the core as a single interrupt line, with a claim/complete register handshake.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; same as apb_timer.
NUM_SRC, 8, number of interrupt sources (2..31); source 0 is wired to apb_timer irq_o at top level.

Ports:
HCLK  input  1  system clock, rising-edge.
HRESETn  input  1  asynchronous active-low reset.
PADDR  input  APB_ADDR_WIDTH  APB address.
PWDATA  input  32  APB write data.
PWRITE  input  1  1 = write.
PSEL  input  1  APB select.
PENABLE  input  1  APB access phase.
PRDATA  output  32  APB read data.
PREADY  output  1  tied 1 (zero wait states).
PSLVERR  output  1  error on unmapped address or bad complete ID.
irq_src_i  input  NUM_SRC  asynchronous interrupt request lines.
irq_o  output  1  registered interrupt to core.

Behaviour:
- Reset: every register is 0, including CTRL, EDGE_CFG, ENABLE, pending, in_service and the sync flops. irq_o = 0, PRDATA = 0, PSLVERR = 0, PREADY = 1. Reset asserted mid-claim drops all in-service state immediately.
- APB access: an access is PSEL & PENABLE; writes commit on that edge. PRDATA is combinational from PADDR while PSEL=1, and 0 otherwise.
- Register map:
  - 0x000 CTRL: bit0 global enable; RW.
  - 0x004 EDGE_CFG: RW; 1 = rising-edge, 0 = level, per source.
  - 0x008 ENABLE: RW mask.
  - 0x00C PENDING: edge sources are W1C; level bits read the synced input and ignore writes.
  - 0x010 CLAIM: read returns ID = index+1 of the lowest-index bit of (pending & ENABLE & ~in_service), or 0 if none. A claim read with nonzero ID sets in_service[ID-1]; for an edge source it also clears that pending bit. Writing ID completes: clears in_service[ID-1].
  - 0x014 IN_SERVICE: RO.
- Unmapped address: PSLVERR = 1 in the access phase, PRDATA = 0, no state change.
- Complete write with ID = 0 or ID > NUM_SRC: PSLVERR = 1, ignored. Complete of a valid ID not currently in service: silently ignored, PSLVERR = 0.
- Synchronisation: 2-flop synchroniser per source. Edge detect compares sync stage 2 against a delayed copy.
- Edge latency: source rising at cycle 0 puts pending[i] = 1 after edge 3 and irq_o = 1 after edge 4.
- Simultaneous edge detect and W1C clear on the same source: set wins.
- Simultaneous claim of source i and a new edge on i: pending stays 1, in_service set.
- Level source: pending is not latched. It follows the input; claim sets in_service only.
- irq_o is registered from CTRL[0] & |(pending & ENABLE & ~in_service). It deasserts one cycle after the claim access when no other eligible source remains.
- Per-source state machine: IDLE -> PENDING (qualified request) -> IN_SERVICE (claim) -> IDLE (complete; re-enters PENDING if an edge was re-latched or the level is still high).
- Upper bits above NUM_SRC read 0; writes to them are ignored.

Decomposition:
- Package apb_irq_ctrl_pkg holds:
  - address localparams CTRL_A, EDGE_CFG_A, ENABLE_A, PENDING_A, CLAIM_A, INSVC_A;
  - ID width localparam $clog2(NUM_SRC+1);
  - src_state_e enum {IDLE, PENDING, IN_SERVICE}.
- Sub-module irq_src_cell, instantiated NUM_SRC times: synchroniser, edge detect, pending and in_service bits, claim/complete/W1C inputs.
- Top level holds the APB decode, priority encoder and irq_o register.

Test Plan:
1. Reset check: HRESETn = 0 for 2 cycles -> all six registers read 0x0, irq_o = 0, PREADY = 1.
2. Timer path: configure apb_timer with CMP_LOWER = 0x10, step = 1, prescale = 0. Set EDGE_CFG = 0x1, ENABLE = 0x1, CTRL = 1 -> irq_o rises 4 cycles after timer irq_o. CLAIM reads 0x1. irq_o = 0 next cycle. Write CLAIM = 0x1 -> IN_SERVICE reads 0x0.
3. Priority: edge-pulse sources 3 and 1 together with ENABLE = 0xFF -> CLAIM reads 0x2, then 0x4, then 0x0. PENDING reads 0x0 after both claims.
4. Level source: EDGE_CFG = 0, hold irq_src_i[5] = 1, claim (reads 0x6) and complete -> irq_o reasserts 1 cycle after complete. Drop the input -> PENDING bit 5 reads 0 after 2 cycles.
5. Errors: read 0x020 -> PSLVERR = 1, PRDATA = 0. Write CLAIM = 0x0 and CLAIM = NUM_SRC+1 -> PSLVERR = 1, IN_SERVICE unchanged.
6. Races: W1C PENDING = 0x4 on the same edge as a new source-2 edge -> PENDING bit 2 reads 1. Assert HRESETn = 0 while IN_SERVICE = 0x1 -> IN_SERVICE = 0 and irq_o = 0 immediately.
